// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int PROD_W        = 2 * DEFAULT_WIDTH;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mult_abs_sign.sv
// Splits an operand into an unsigned magnitude and a sign flag; -2^(WIDTH-1) maps to 2^(WIDTH-1).
module mult_abs_sign
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    assign sign = signed_mode & operand[WIDTH-1];
    assign mag  = sign ? (~operand + {{(WIDTH-1){1'b0}}, 1'b1}) : operand;

endmodule

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with valid/ready handshake on both sides, one add per clock.
module seq_mult_hs
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    c,
    output logic                  busy
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplr;
    logic [PW:0]       acc;
    logic [CW-1:0]     cnt;
    logic              neg;

    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              a_sign;
    logic              b_sign;
    logic [WIDTH:0]    upper_sum;
    logic              accept;

    mult_abs_sign #(.WIDTH(WIDTH)) u_abs_a (
        .operand     (a),
        .signed_mode (signed_mode),
        .mag         (a_mag),
        .sign        (a_sign)
    );

    mult_abs_sign #(.WIDTH(WIDTH)) u_abs_b (
        .operand     (b),
        .signed_mode (signed_mode),
        .mag         (b_mag),
        .sign        (b_sign)
    );

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) | (state == FIXUP);

    // The upper half is one bit wider than an operand so the add never overflows before the shift.
    assign upper_sum = acc[PW:WIDTH] + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= {1'b0, upper_sum, acc[WIDTH-1:1]};
                    mplr <= mplr >> 1;
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= FIXUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIXUP: begin
                    c     <= neg ? (~acc[PW-1:0] + {{(PW-1){1'b0}}, 1'b1}) : acc[PW-1:0];
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= in_valid ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Operand capture is shared by the IDLE start and the DONE back-to-back handoff.
            if (accept) begin
                mcand <= a_mag;
                mplr  <= b_mag;
                neg   <= a_sign ^ b_sign;
                acc   <= '0;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
Parametrised iterative shift-add multiplier. It is the sequential successor to the team's 16x16 combinational full-adder array multiplier. It accepts WIDTH-bit operands over a valid/ready handshake and supports unsigned or two's-complement signed operation, selected per transaction. It produces a 2*WIDTH-bit product after a fixed latency and holds it until the consumer accepts it. It trades the array's area for one add per clock and sits between a producer and consumer of arithmetic results.

Parameters:
WIDTH, 16, operand width in bits (legal range 2..64); product width is 2*WIDTH.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode are valid this cycle
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement signed, 0 = unsigned; sampled with a/b
out_valid  output  1  product c is valid
out_ready  input  1  consumer accepts c this cycle
c  output  2*WIDTH  product
busy  output  1  high in RUN or FIXUP state

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, c=0, busy=0, counter=0. Reset mid-operation discards the in-flight transaction; no output is produced for it.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register the following and go to RUN:
  - |a| and |b| as WIDTH-bit unsigned magnitudes (signed_mode=1 with MSB set: two's-complement negate).
  - neg = signed_mode & (a[W-1]^b[W-1]).
  - acc = 0, cnt = 0.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits WIDTH bits unsigned; no overflow.
- RUN: each cycle, if multiplier LSB=1, add the multiplicand magnitude into the upper half of a (2*WIDTH+1)-bit accumulator, then shift right 1; cnt++. After WIDTH RUN cycles (cnt==WIDTH-1 at the edge), go to FIXUP.
- FIXUP: c <= neg ? -acc[2W-1:0] : acc[2W-1:0] (modulo 2^(2W)); go to DONE.
- DONE: out_valid=1, c stable. Hold both while out_ready=0.
  - On out_ready=1: if in_valid=1 the same cycle, accept new operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only, never from in_valid.
- Latency: accept at edge E0; out_valid is high in the cycle following edge E(WIDTH+1). WIDTH=16 gives 17 cycles. Fixed, independent of operand values. Zero operands are not short-cut.
- Throughput: one product per WIDTH+2 cycles with out_ready held high.
- a, b and signed_mode are ignored outside the accepting cycle. Changing them mid-RUN has no effect.
- c keeps its last value after DONE->IDLE until the next FIXUP; only out_valid qualifies it.
- Counter width: clog2(WIDTH).

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, RUN, FIXUP, DONE)
  - function clog2
  - localparam PROD_W = 2*WIDTH helper
- One natural sub-module: mult_abs_sign (operand in, signed_mode in; magnitude and sign out), instantiated for a and b.
- Accumulate/shift datapath stays in the top-level.

Test Plan:
- WIDTH=16, unsigned, a=0x000F, b=0x000F, out_ready=1 -> c=0x000000E1 (225), out_valid high exactly 17 cycles after acceptance.
- Unsigned a=0xFFFF, b=0xFFFF -> c=0xFFFE0001. Then signed_mode=1 with the same operands (-1*-1) -> c=0x00000001.
- Signed a=0x8000, b=0x8000 -> c=0x40000000. Signed a=0xFFFD (-3), b=0x0005 -> c=0xFFFFFFF1 (-15). Signed a=0x8000, b=0x0001 -> c=0xFFFF8000.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid -> c and out_valid stable, in_ready=0.
  - Raise out_ready with in_valid=1 (a=3, b=4) -> same-edge handoff; next product 12 appears 17 cycles later.
- Reset mid-op: assert rst for 1 cycle at RUN cycle 8 of a=0x1234, b=0x5678 -> next cycle state IDLE, out_valid=0, c=0, in_ready=1; no stale product ever emitted.
- Parameter sweep WIDTH=4 and WIDTH=32, random operands, both modes, random out_ready -> every c matches the reference model; latency WIDTH+1.
